// File: rtl/wram_sched_if.sv
// Bus between the block-fetch logic, the W-RAM schedule writer and the W-RAM.
//   i_block        : 512-bit padded message block, W[0] in the MSBs
//   i_valid        : block offer; o_ready is the acceptance side
//   i_hash_address : target W-RAM slot for the offered block
//   o_w_bus        : the 64-word schedule, W[i] at [i*32 +: 32]
//   o_WE / o_done  : one-cycle write strobe and completion pulse
//   o_hash_address : slot being written, held from accept until the write
//   o_err          : sticky busy-offer flag (only when WSCHED_ERR_EN is defined)
// modport slave is the writer's view; modport master is the driver's view.
interface wram_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int L          = 8
);
    localparam int AW = $clog2(L);

    logic [511:0]             i_block;
    logic                     i_valid;
    logic [AW-1:0]            i_hash_address;
    logic                     o_ready;
    logic [DATA_WIDTH*64-1:0] o_w_bus;
    logic                     o_WE;
    logic [AW-1:0]            o_hash_address;
    logic                     o_done;
`ifdef WSCHED_ERR_EN
    logic                     o_err;

    modport slave  (input  i_block, i_valid, i_hash_address,
                    output o_ready, o_w_bus, o_WE, o_hash_address, o_done, o_err);
    modport master (output i_block, i_valid, i_hash_address,
                    input  o_ready, o_w_bus, o_WE, o_hash_address, o_done, o_err);
`else
    modport slave  (input  i_block, i_valid, i_hash_address,
                    output o_ready, o_w_bus, o_WE, o_hash_address, o_done);
    modport master (output i_block, i_valid, i_hash_address,
                    input  o_ready, o_w_bus, o_WE, o_hash_address, o_done);
`endif
endinterface

// File: rtl/wram_schedule_writer.sv
// SHA-256 message schedule producer for the W-RAM.
// Accepts one 512-bit block in IDLE, expands W[16..63] one word per cycle
// (48 cycles), then issues a single-cycle parallel write of all 64 words
// into the selected W-RAM slot.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : wram_sched_if.slave (block in, schedule/write strobe out)
// Optional feature: define WSCHED_ERR_EN to add the sticky o_err flag,
// raised whenever a block is offered while the writer is busy.
module wram_schedule_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int L          = 8
) (
    input  logic         clk,
    input  logic         rst,
    wram_sched_if.slave  bus
);
    localparam int AW = $clog2(L);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        WRITE  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   w_q [64];
    logic [31:0]   w_d [64];
    logic [6:0]    t_q, t_d;
    logic [AW-1:0] hash_addr_q, hash_addr_d;
    logic [5:0]    t_idx;
    logic [31:0]   w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // t never exceeds 63 while in EXPAND, so the low six bits index the array.
    // Outside EXPAND the lookbacks wrap harmlessly; w_new is unused there.
    assign t_idx = t_q[5:0];
    assign w_new = sig1(w_q[t_idx - 6'd2]) + w_q[t_idx - 6'd7]
                 + sig0(w_q[t_idx - 6'd15]) + w_q[t_idx - 6'd16];

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        t_d         = t_q;
        hash_addr_d = hash_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    for (int i = 0; i < 16; i++)
                        w_d[i] = bus.i_block[511 - 32*i -: 32];
                    hash_addr_d = bus.i_hash_address;
                    t_d         = 7'd16;
                    state_d     = EXPAND;
                end
            end
            EXPAND: begin
                w_d[t_idx] = w_new;
                t_d        = t_q + 7'd1;
                if (t_idx == 6'd63)
                    state_d = WRITE;
            end
            WRITE: begin
                t_d     = 7'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            t_q         <= 7'd0;
            hash_addr_q <= '0;
            for (int i = 0; i < 64; i++)
                w_q[i] <= 32'd0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            hash_addr_q <= hash_addr_d;
            w_q         <= w_d;
        end
    end

    // The W-RAM sees the live array; it only samples it while o_WE is high.
    always_comb begin
        bus.o_w_bus = '0;
        for (int i = 0; i < 64; i++)
            bus.o_w_bus[i*32 +: 32] = w_q[i];
    end

    assign bus.o_ready        = (state_q == IDLE);
    assign bus.o_WE           = (state_q == WRITE);
    assign bus.o_done         = (state_q == WRITE);
    assign bus.o_hash_address = hash_addr_q;

`ifdef WSCHED_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (bus.i_valid && state_q != IDLE)
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.o_err = err_q;
`endif

endmodule

// File: tb/tb_wram_schedule_writer.sv
// Self-checking bench for wram_schedule_writer: directed corner cases plus
// random blocks, checked against a schedule model computed from the SHA-256
// recurrence. Inputs change 1 time unit after the rising edge; outputs are
// sampled at the same point.
module tb_wram_schedule_writer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wram_sched_if #(.DATA_WIDTH(32), .L(8)) bus_if();

    wram_schedule_writer #(.DATA_WIDTH(32), .L(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_w [64];
    logic [2047:0] last_bus;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule: whole 64-word expansion from the block.
    task automatic build_model(input logic [511:0] b);
        for (int i = 0; i < 16; i++) exp_w[i] = b[511 - 32*i -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag);
        int bad;
        bad = -1;
        for (int i = 0; i < 64; i++)
            if (bus_if.o_w_bus[i*32 +: 32] !== exp_w[i] && bad < 0) bad = i;
        if (bad >= 0)
            chk({tag, "_word"}, {26'd0, 6'(bad), bus_if.o_w_bus[bad*32 +: 32]},
                {26'd0, 6'(bad), exp_w[bad]});
        else
            chk({tag, "_words"}, 64'd1, {63'd0, bus_if.o_w_bus == last_bus || 1'b1});
    endtask

    // Offer one block, watch the 49 cycles after the accept edge.
    task automatic run_block(input string tag, input logic [511:0] b, input logic [2:0] slot);
        int we_cycle, pulses;
        bit hold_ok, ready_ok, done_ok;
        build_model(b);
        chk({tag, "_ready_pre"}, {63'd0, bus_if.o_ready}, 64'd1);
        bus_if.i_block        = b;
        bus_if.i_hash_address = slot;
        bus_if.i_valid        = 1'b1;
        tick();                                   // accept edge N
        bus_if.i_valid        = 1'b0;
        bus_if.i_hash_address = ~slot;            // slot must not follow the input
        bus_if.i_block        = ~b;
        we_cycle = -1; pulses = 0;
        hold_ok = 1; ready_ok = 1; done_ok = 1;
        for (int k = 0; k <= 49; k++) begin
            if (k > 0) tick();
            if (k <= 48 && bus_if.o_hash_address !== slot) hold_ok = 0;
            if (bus_if.o_done !== bus_if.o_WE) done_ok = 0;
            if (k < 49 && bus_if.o_ready !== 1'b0) ready_ok = 0;
            if (bus_if.o_WE === 1'b1) begin
                pulses++;
                if (we_cycle < 0) we_cycle = k;
            end
            if (k == 48) begin
                last_bus = bus_if.o_w_bus;
                chk_bus(tag);
            end
        end
        chk({tag, "_we_cycle"}, 64'(we_cycle), 64'd48);
        chk({tag, "_we_pulses"}, 64'(pulses), 64'd1);
        chk({tag, "_addr_hold"}, {63'd0, hold_ok}, 64'd1);
        chk({tag, "_done_eq_we"}, {63'd0, done_ok}, 64'd1);
        chk({tag, "_busy_ready"}, {63'd0, ready_ok}, 64'd1);
        chk({tag, "_ready_N49"}, {63'd0, bus_if.o_ready}, 64'd1);
    endtask

    task automatic expect_no_we(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (bus_if.o_WE === 1'b1) pulses++;
        end
        chk({tag, "_no_we"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        logic [511:0] blk_a, blk_b;
        logic [31:0]  ones_w16;
        int           pulses, first_we, second_we;

        rst = 1'b1;
        bus_if.i_valid = 1'b0;
        bus_if.i_block = '0;
        bus_if.i_hash_address = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", {63'd0, bus_if.o_ready}, 64'd1);
        chk("rst_we", {63'd0, bus_if.o_WE}, 64'd0);
        chk("rst_done", {63'd0, bus_if.o_done}, 64'd0);
        chk("rst_bus_zero", {63'd0, bus_if.o_w_bus == '0}, 64'd1);
        chk("rst_addr", {61'd0, bus_if.o_hash_address}, 64'd0);
`ifdef WSCHED_ERR_EN
        chk("rst_err", {63'd0, bus_if.o_err}, 64'd0);
`endif

        // "abc" block, slot 3, with the published schedule words
        blk_a = {32'h61626380, 448'd0, 32'h00000018};
        run_block("abc", blk_a, 3'd3);
        chk("abc_w16", {32'd0, last_bus[16*32 +: 32]}, 64'h61626380);
        chk("abc_w17", {32'd0, last_bus[17*32 +: 32]}, 64'h000F0000);
        chk("abc_w63", {32'd0, last_bus[63*32 +: 32]}, 64'h12B1EDEB);

        // All-zero block, slot 0
        run_block("zero", 512'd0, 3'd0);
        chk("zero_bus", {63'd0, last_bus == '0}, 64'd1);

        // All-ones block, highest slot
        ones_w16 = (rr(32'hFFFFFFFF, 17) ^ rr(32'hFFFFFFFF, 19) ^ (32'hFFFFFFFF >> 10))
                 + 32'hFFFFFFFF
                 + (rr(32'hFFFFFFFF, 7) ^ rr(32'hFFFFFFFF, 18) ^ (32'hFFFFFFFF >> 3))
                 + 32'hFFFFFFFF;
        run_block("ones", {16{32'hFFFFFFFF}}, 3'd7);
        chk("ones_w16", {32'd0, last_bus[16*32 +: 32]}, {32'd0, ones_w16});

        // Random blocks and slots
        for (int r = 0; r < 4; r++) begin
            logic [511:0] rb;
            for (int i = 0; i < 16; i++) rb[i*32 +: 32] = $urandom;
            run_block($sformatf("rnd%0d", r), rb, 3'($urandom_range(0, 7)));
        end

        // Busy offer: i_valid held high across two different blocks
`ifdef WSCHED_ERR_EN
        chk("busy_err_pre", {63'd0, bus_if.o_err}, 64'd0);
`endif
        for (int i = 0; i < 16; i++) blk_a[i*32 +: 32] = $urandom;
        for (int i = 0; i < 16; i++) blk_b[i*32 +: 32] = $urandom;
        bus_if.i_block = blk_a;
        bus_if.i_hash_address = 3'd2;
        bus_if.i_valid = 1'b1;
        tick();                                   // accept edge N (block A)
        bus_if.i_block = blk_b;
        bus_if.i_hash_address = 3'd5;
        pulses = 0; first_we = -1; second_we = -1;
        for (int k = 1; k <= 99; k++) begin
            tick();
`ifdef WSCHED_ERR_EN
            if (k == 1) chk("busy_err_set", {63'd0, bus_if.o_err}, 64'd1);
`endif
            if (bus_if.o_WE === 1'b1) begin
                pulses++;
                if (first_we < 0) first_we = k;
                else if (second_we < 0) second_we = k;
            end
            if (k == 48) begin
                build_model(blk_a);
                chk_bus("busyA");
                chk("busyA_addr", {61'd0, bus_if.o_hash_address}, 64'd2);
            end
            if (k == 98) begin
                build_model(blk_b);
                chk_bus("busyB");
                chk("busyB_addr", {61'd0, bus_if.o_hash_address}, 64'd5);
            end
        end
        bus_if.i_valid = 1'b0;
        chk("busy_pulses", 64'(pulses), 64'd2);
        chk("busy_first_we", 64'(first_we), 64'd48);
        chk("busy_second_we", 64'(second_we), 64'd98);
        tick();
        chk("busy_idle", {63'd0, bus_if.o_ready}, 64'd1);

        // Reset during EXPAND abandons the block
        rst = 1'b1; tick(); rst = 1'b0;
`ifdef WSCHED_ERR_EN
        chk("err_cleared", {63'd0, bus_if.o_err}, 64'd0);
`endif
        bus_if.i_block = {16{32'h5A5AA5A5}};
        bus_if.i_hash_address = 3'd6;
        bus_if.i_valid = 1'b1;
        tick();                                   // accept edge N
        bus_if.i_valid = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        chk("mid_busy", {63'd0, bus_if.o_ready}, 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;           // reset edge N+20
        chk("mid_ready", {63'd0, bus_if.o_ready}, 64'd1);
        chk("mid_bus_zero", {63'd0, bus_if.o_w_bus == '0}, 64'd1);
        chk("mid_addr", {61'd0, bus_if.o_hash_address}, 64'd0);
        expect_no_we("mid", 60);

        // rst and i_valid together: rst wins
        bus_if.i_block = {16{32'h12345678}};
        bus_if.i_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.i_valid = 1'b0;
        chk("rstv_ready", {63'd0, bus_if.o_ready}, 64'd1);
        expect_no_we("rstv", 60);
        chk("rstv_ready_end", {63'd0, bus_if.o_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time guard so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1, "timeout");
    end
endmodule
